piso_serializer: RTL and testbench

Parallel-in/serial-out stage that feeds the single-bit `inp` port of the Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and buffers one pending word while another is shifting. It emits one bit per `clk` cycle with a qualifying valid, then inserts an optional gap between words. When idle, the serial line holds a defined level so the detector never sees a spurious pattern.

---
 rtl/ser_pkg.sv | 19 +
 rtl/ser_hold_reg.sv | 63 ++++++
 rtl/piso_serializer.sv | 149 ++++++++++++++
 tb/tb_piso_serializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the parallel-in/serial-out serializer:
//   - ser_state_e     : serializer FSM states (IDLE, SHIFT, GAP)
//   - GAP_W           : width of the inter-word gap counter
//   - IDLE_LEVEL_DEF  : default level of the serial line when no bit is sent
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    localparam int   GAP_W          = 4;
    localparam logic IDLE_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/ser_hold_reg.sv
// ---------------------------------------------------------------------------
// ser_hold_reg
// One-entry valid/ready holding buffer in front of the shift register.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears the full flag)
//   din        : parallel word offered upstream
//   din_valid  : din is offered
//   take       : consumer moves the held word out this edge (only when full)
//   ready      : buffer can accept a word (registered-derived, low in reset)
//   full       : buffer holds a word
//   dout       : held word
// ---------------------------------------------------------------------------
module ser_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             take,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept;

    // ready depends only on the full flag (and reset), never on din_valid.
    assign ready  = !full_q && !rst;
    assign accept = din_valid && ready;

    // take only happens while full and accept only while empty, so the two
    // never collide on the same edge.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (take) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
            data_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Data path carries no reset; the full flag qualifies it.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in/serial-out stage feeding a single-bit sequence detector input.
// Accepts WIDTH-bit words over valid/ready, buffers one pending word while
// another shifts, emits one bit per cycle, then optionally idles GAP_CYCLES
// cycles between words. The line sits at IDLE_LEVEL whenever no bit is sent.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   din        : parallel word
//   din_valid  : din offered
//   din_ready  : a word can be taken (transfer = din_valid && din_ready)
//   ser_out    : serial bit (IDLE_LEVEL when ser_valid is low)
//   ser_valid  : ser_out carries a data bit this cycle
//   busy       : FSM not idle or a word is waiting in the holding register
//   bit_idx    : bits already sent from the current word (0 outside SHIFT)
// ---------------------------------------------------------------------------
module piso_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic                     ser_out,
    output logic                     ser_valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             take;

    // Advance the shift register so the next bit to send sits at the output tap.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    ser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .take      (take),
        .ready     (din_ready),
        .full      (hold_full),
        .dout      (hold_data)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        take    = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    take    = 1'b1;
                    sr_d    = hold_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                sr_d  = shift_one(sr_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gcnt_d  = GAP_LOAD;
                    end else if (hold_full) begin
                        // Seamless reload: next word's first bit follows directly.
                        take = 1'b1;
                        sr_d = hold_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            GAP: begin
                if (gcnt_q == '0) begin
                    if (hold_full) begin
                        take    = 1'b1;
                        sr_d    = hold_data;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Shift data is qualified by the FSM state, so it needs no reset.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign ser_valid = (state_q == SHIFT);
    assign ser_out   = ser_valid ? ((MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_LEVEL;
    assign busy      = (state_q != IDLE) || hold_full;
    assign bit_idx   = ser_valid ? cnt_q : '0;

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// tb_piso_serializer
// Three serializer instances (MSB-first, LSB-first, MSB-first with a 2-cycle
// gap) share clock and reset. Inputs are driven and outputs captured on the
// falling clock edge; expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din       [3];
    logic       din_valid [3];
    logic       din_ready [3];
    logic       ser_out   [3];
    logic       ser_valid [3];
    logic       busy      [3];
    logic [2:0] bit_idx   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
        .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .busy(busy[0]), .bit_idx(bit_idx[0]));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
        .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .busy(busy[1]), .bit_idx(bit_idx[1]));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) u_gap (
        .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]), .din_ready(din_ready[2]),
        .ser_out(ser_out[2]), .ser_valid(ser_valid[2]), .busy(busy[2]), .bit_idx(bit_idx[2]));

    // Per-cycle capture of one instance, indexed by falling edge within a run.
    logic       cap_sv   [64];
    logic       cap_so   [64];
    logic       cap_rdy  [64];
    logic       cap_busy [64];
    logic [2:0] cap_bi   [64];
    int         pop_cyc  [3];

    typedef struct {
        int         sel;
        logic [7:0] word;
        logic [7:0] seq;        // bits in transmit order, first bit at [7]
        logic       busy_after; // busy on the first cycle after the last bit
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer up to three words back-to-back on instance i while capturing its
    // outputs for ncyc falling edges. A word counts as accepted when it is
    // presented while din_ready is high.
    task automatic run(input int i, input int nw, input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input int ncyc);
        logic [7:0] q [3];
        int head;
        q[0] = w0; q[1] = w1; q[2] = w2;
        head = 0;
        for (int k = 0; k < 3; k++) pop_cyc[k] = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cap_sv[c]   = ser_valid[i];
            cap_so[c]   = ser_out[i];
            cap_rdy[c]  = din_ready[i];
            cap_busy[c] = busy[i];
            cap_bi[c]   = bit_idx[i];
            if (head < nw && c < ncyc - 1) begin
                din[i]       = q[head];
                din_valid[i] = 1'b1;
                if (din_ready[i]) begin
                    pop_cyc[head] = c;
                    head++;
                end
            end else begin
                din_valid[i] = 1'b0;
            end
        end
        din_valid[i] = 1'b0;
    endtask

    // Compare an MSB-first word against the capture starting at cycle start.
    task automatic check_word(input string name, input int start, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            chk({name, "_valid"}, int'(cap_sv[start+k]), 1);
            chk({name, "_bit"},   int'(cap_so[start+k]), int'(w[7-k]));
            chk({name, "_idx"},   int'(cap_bi[start+k]), k);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 8'hA5, 8'b10100101, 1'b0};
        tbl[1] = '{1, 8'h01, 8'b10000000, 1'b0};
        tbl[2] = '{0, 8'h3C, 8'b00111100, 1'b0};
        tbl[3] = '{1, 8'h96, 8'b01101001, 1'b0};
        tbl[4] = '{2, 8'h81, 8'b10000001, 1'b1};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[i]       = 8'h00;
            din_valid[i] = 1'b0;
        end

        // Reset state
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ser_valid", int'(ser_valid[i]), 0);
            chk("rst_ser_out",   int'(ser_out[i]),   1);
            chk("rst_busy",      int'(busy[i]),      0);
            chk("rst_bit_idx",   int'(bit_idx[i]),   0);
            chk("rst_din_ready", int'(din_ready[i]), 0);
        end
        #20 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_ready", int'(din_ready[i]), 1);
            chk("post_rst_valid", int'(ser_valid[i]), 0);
        end

        // Single words from idle
        for (int t = 0; t < 5; t++) begin
            run(tbl[t].sel, 1, tbl[t].word, 8'h00, 8'h00, 12);
            chk("single_accept",    pop_cyc[0], 0);
            chk("single_lat_valid", int'(cap_sv[1]),   0);
            chk("single_hold_busy", int'(cap_busy[1]), 1);
            chk("single_hold_rdy",  int'(cap_rdy[1]),  0);
            for (int k = 0; k < 8; k++) begin
                chk("single_valid", int'(cap_sv[2+k]), 1);
                chk("single_bit",   int'(cap_so[2+k]), int'(tbl[t].seq[7-k]));
                chk("single_idx",   int'(cap_bi[2+k]), k);
            end
            chk("single_end_valid", int'(cap_sv[10]),   0);
            chk("single_end_level", int'(cap_so[10]),   1);
            chk("single_end_busy",  int'(cap_busy[10]), int'(tbl[t].busy_after));
        end

        // Back-to-back, no gap: F0 then 0F as 16 contiguous bits
        run(0, 2, 8'hF0, 8'h0F, 8'h00, 20);
        chk("b2b_rdy_full",   int'(cap_rdy[1]), 0);
        chk("b2b_rdy_free",   int'(cap_rdy[2]), 1);
        chk("b2b_accept2",    pop_cyc[1], 2);
        chk("b2b_rdy_full2",  int'(cap_rdy[9]), 0);
        check_word("b2b_w1", 2, 8'hF0);
        check_word("b2b_w2", 10, 8'h0F);
        chk("b2b_rdy_reload", int'(cap_rdy[10]), 1);
        chk("b2b_end_valid",  int'(cap_sv[18]), 0);
        chk("b2b_end_level",  int'(cap_so[18]), 1);

        // Two-cycle gap between words
        run(2, 2, 8'h81, 8'h42, 8'h00, 22);
        chk("gap_accept2", pop_cyc[1], 2);
        check_word("gap_w1", 2, 8'h81);
        chk("gap0_valid", int'(cap_sv[10]), 0);
        chk("gap0_level", int'(cap_so[10]), 1);
        chk("gap1_valid", int'(cap_sv[11]), 0);
        chk("gap1_level", int'(cap_so[11]), 1);
        check_word("gap_w2", 12, 8'h42);
        chk("gap_end_valid", int'(cap_sv[20]), 0);

        // Back-pressure: three words offered continuously
        run(0, 3, 8'h11, 8'h22, 8'h33, 28);
        chk("bp_accept1", pop_cyc[0], 0);
        chk("bp_accept2", pop_cyc[1], 2);
        chk("bp_accept3", pop_cyc[2], 10);
        for (int c = 3; c < 10; c++) chk("bp_rdy_low", int'(cap_rdy[c]), 0);
        check_word("bp_w1", 2, 8'h11);
        check_word("bp_w2", 10, 8'h22);
        check_word("bp_w3", 18, 8'h33);
        chk("bp_end_valid", int'(cap_sv[26]), 0);

        // Reset mid-word with a word pending in hold
        run(0, 2, 8'hC3, 8'h5A, 8'h00, 5);
        chk("mid_shifting", int'(cap_sv[4]), 1);
        chk("mid_pending",  pop_cyc[1], 2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", int'(ser_valid[0]), 0);
        chk("mid_rst_out",   int'(ser_out[0]),   1);
        chk("mid_rst_busy",  int'(busy[0]),      0);
        chk("mid_rst_idx",   int'(bit_idx[0]),   0);
        chk("mid_rst_ready", int'(din_ready[0]), 0);
        #97 rst = 1'b0;
        run(0, 0, 8'h00, 8'h00, 8'h00, 12);
        chk("after_rst_ready", int'(cap_rdy[0]), 1);
        for (int c = 0; c < 12; c++) begin
            chk("after_rst_quiet", int'(cap_sv[c]), 0);
            chk("after_rst_busy",  int'(cap_busy[c]), 0);
        end
        run(0, 1, 8'h5A, 8'h00, 8'h00, 12);
        chk("after_rst_lat", int'(cap_sv[1]), 0);
        check_word("after_rst_w", 2, 8'h5A);
        chk("after_rst_end", int'(cap_sv[10]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
